seq_detect_param: RTL and testbench

//  Parametrised serial pattern detector, one bit per enabled clock.

---
 rtl/seq_detect_param.sv | 86 ++++++++
 tb/tb_seq_detect_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlapping / non-overlapping modes.
// Build option SEQDET_SAT_EN: counters saturate instead of wrapping.
module seq_detect_param #(
  parameter int unsigned             PAT_W   = 4,
  parameter logic [PAT_W-1:0]        PATTERN = 4'b1001,
  parameter int unsigned             CNT_W   = 8,
  localparam int unsigned            PW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             a,
  input  logic             mode,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [PW-1:0]    prog
);

  localparam logic [PW-1:0] FillFull = PW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PW-1:0]    fill;

  logic [PAT_W-1:0] win;
  logic [PW-1:0]    fill_nx;
  logic             hit;
  logic [PW-1:0]    prog_d;
  logic [CNT_W-1:0] match_cnt_inc;
  logic [CNT_W-1:0] bit_cnt_inc;

  assign win     = {hist[PAT_W-2:0], a};
  assign fill_nx = (fill == FillFull) ? FillFull : fill + PW'(1);
  assign hit     = (fill_nx == FillFull) && (win == PATTERN);

  // Longest suffix of the valid window that is also a prefix of the pattern.
  always_comb begin
    logic ok;
    prog_d = '0;
    ok     = 1'b0;
    for (int unsigned k = 1; k <= PAT_W; k++) begin
      ok = (PW'(k) <= fill_nx);
      for (int unsigned j = 0; j < k; j++) begin
        if (win[j] != PATTERN[PAT_W-k+j]) ok = 1'b0;
      end
      if (ok) prog_d = PW'(k);
    end
  end

`ifdef SEQDET_SAT_EN
  assign match_cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
  assign bit_cnt_inc   = (&bit_cnt) ? bit_cnt : bit_cnt + CNT_W'(1);
`else
  assign match_cnt_inc = match_cnt + CNT_W'(1);
  assign bit_cnt_inc   = bit_cnt + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      bit_cnt   <= '0;
      prog      <= '0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      bit_cnt   <= '0;
      prog      <= '0;
    end else if (en) begin
      hist    <= win;
      fill    <= (hit && mode) ? '0 : fill_nx;
      match   <= hit;
      prog    <= prog_d;
      bit_cnt <= bit_cnt_inc;
      if (hit) match_cnt <= match_cnt_inc;
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (default and CNT_W=2 instances).
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, clr, en, a, mode;
  logic       match;
  logic [7:0] match_cnt, bit_cnt;
  logic [2:0] prog;

  logic       clr2, en2, a2, mode2;
  logic       match2;
  logic [1:0] match_cnt2, bit_cnt2;
  logic [2:0] prog2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a), .mode(mode),
    .match(match), .match_cnt(match_cnt), .bit_cnt(bit_cnt), .prog(prog)
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .en(en2), .a(a2), .mode(mode2),
    .match(match2), .match_cnt(match_cnt2), .bit_cnt(bit_cnt2), .prog(prog2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bit_in(input logic b);
    en = 1'b1;
    a  = b;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic bit_in2(input logic b);
    en2 = 1'b1;
    a2  = b;
    @(posedge clk);
    #1;
    en2 = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_match"}, 32'(match), 0);
    chk({tag, "_mcnt"}, 32'(match_cnt), 0);
    chk({tag, "_bcnt"}, 32'(bit_cnt), 0);
    chk({tag, "_prog"}, 32'(prog), 0);
  endtask

  logic [31:0] s1, e1;
  logic [6:0]  s2;
  logic [12:0] s6;

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; a = 1'b0; mode = 1'b0;
    clr2 = 1'b0; en2 = 1'b0; a2 = 1'b0; mode2 = 1'b0;
    #2;
    chk_zero("reset");
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: long stream, overlapping mode; pulses after bits 4, 8, 32.
    s1 = 32'b10011001011000100000100011101001;
    e1 = 32'b00010001000000000000000000000001;
    for (int i = 31; i >= 0; i--) begin
      bit_in(s1[i]);
      chk($sformatf("t1_match_bit%0d", 32 - i), 32'(match), 32'(e1[i]));
    end
    chk("t1_mcnt", 32'(match_cnt), 3);
    chk("t1_bcnt", 32'(bit_cnt), 32);
    chk("t1_prog", 32'(prog), 4);
    idle();
    chk("t1_match_drop", 32'(match), 0);

    // Test 2a: 1001001 overlapping -> 2 matches.
    do_clr();
    s2 = 7'b1001001;
    for (int i = 6; i >= 0; i--) bit_in(s2[i]);
    chk("t2a_match", 32'(match), 1);
    chk("t2a_mcnt", 32'(match_cnt), 2);
    chk("t2a_prog", 32'(prog), 4);

    // Test 2b: same stream non-overlapping -> 1 match.
    do_clr();
    mode = 1'b1;
    for (int i = 6; i >= 4; i--) bit_in(s2[i]);
    chk("t2b_prog3", 32'(prog), 3);
    bit_in(s2[3]);
    chk("t2b_match4", 32'(match), 1);
    chk("t2b_prog4", 32'(prog), 4);
    for (int i = 2; i >= 0; i--) bit_in(s2[i]);
    chk("t2b_match7", 32'(match), 0);
    chk("t2b_mcnt", 32'(match_cnt), 1);
    chk("t2b_bcnt", 32'(bit_cnt), 7);
    // Only 3 bits valid after the restart: longest suffix of 001 prefixing 1001 is 1.
    chk("t2b_prog7", 32'(prog), 1);
    mode = 1'b0;

    // Test 3: en toggling over 1001.
    do_clr();
    bit_in(1'b1);
    chk("t3_prog1", 32'(prog), 1);
    a = 1'b0;
    idle();
    chk("t3_hold_prog", 32'(prog), 1);
    chk("t3_hold_bcnt", 32'(bit_cnt), 1);
    bit_in(1'b0);
    idle();
    bit_in(1'b0);
    idle();
    chk("t3_hold_prog3", 32'(prog), 3);
    chk("t3_nomatch", 32'(match), 0);
    bit_in(1'b1);
    chk("t3_match", 32'(match), 1);
    a = 1'b1;
    idle();
    chk("t3_match_drop", 32'(match), 0);
    chk("t3_mcnt", 32'(match_cnt), 1);
    chk("t3_bcnt", 32'(bit_cnt), 4);
    chk("t3_prog", 32'(prog), 4);

    // Test 4: async reset mid-stream.
    do_clr();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    chk("t4_prog_pre", 32'(prog), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t4_async");
    #1;
    rst = 1'b0;
    bit_in(1'b1);
    chk("t4_no_stale", 32'(match), 0);
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    chk("t4_match", 32'(match), 1);
    chk("t4_mcnt", 32'(match_cnt), 1);

    // Test 5: clr with en on the final bit.
    do_clr();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    clr = 1'b1;
    bit_in(1'b1);
    clr = 1'b0;
    chk_zero("t5_clr");

    // Test 6: CNT_W=2, 4 matches over 13 bits.
    s6 = 13'b1001001001001;
    for (int i = 12; i >= 0; i--) bit_in2(s6[i]);
    chk("t6_match", 32'(match2), 1);
`ifdef SEQDET_SAT_EN
    chk("t6_mcnt", 32'(match_cnt2), 3);
    chk("t6_bcnt", 32'(bit_cnt2), 3);
`else
    chk("t6_mcnt", 32'(match_cnt2), 0);
    chk("t6_bcnt", 32'(bit_cnt2), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
